// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bundle between the CPU control FSM and the MULT/DIV sequencer.
//   start/op/a/b        : request and operands, driven by the control FSM (master)
//   busy/done           : stall indication and one-cycle completion pulse
//   hiwrite/lowrite/hi/lo : HI/LO register load strobes and data
//   divby0              : one-cycle pulse for a DIV by zero
`timescale 1ns/1ps
interface muldiv_sequencer_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        hiwrite;
  logic        lowrite;
  logic        divby0;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hiwrite, lowrite, divby0, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hiwrite, lowrite, divby0, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multicycle sequencer for the signed MULT/DIV unit.
// Runs 32 iterations of radix-2 shift-add multiply or restoring divide on
// operand magnitudes, then sign-corrects and presents the 64-bit result.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of muldiv_sequencer_if (start/op/a/b in;
//           busy/done/hiwrite/lowrite/divby0/hi/lo out, all registered)
`timescale 1ns/1ps
module muldiv_sequencer (
  input logic           clk,
  input logic           reset,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t      state;
  logic        op_div;
  logic        res_neg;
  logic        rem_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] acc;   // MULT: {P, multiplier}; DIV: acc[31:0] is the quotient Q
  logic [31:0] rem;   // DIV remainder; always < |b| between iterations, so 32 bits suffice
  logic [5:0]  cnt;

  logic [31:0] a_abs_in;
  logic [31:0] b_abs_in;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] prod_signed;
  logic [31:0] q_signed;
  logic [31:0] r_signed;

  always_comb begin
    a_abs_in    = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
    b_abs_in    = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
    mul_sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
    div_shift   = {rem, acc[31]};
    div_ge      = (div_shift >= {1'b0, b_mag});
    // the difference is below |b| and therefore fits in 32 bits
    div_diff    = div_shift[31:0] - b_mag;
    prod_signed = res_neg ? (~acc + 64'd1) : acc;
    q_signed    = res_neg ? (~acc[31:0] + 32'd1) : acc[31:0];
    r_signed    = rem_neg ? (~rem + 32'd1) : rem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_div      <= 1'b0;
      res_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      a_mag       <= '0;
      b_mag       <= '0;
      acc         <= '0;
      rem         <= '0;
      bus.hi      <= '0;
      bus.lo      <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.hiwrite <= 1'b0;
      bus.lowrite <= 1'b0;
      bus.divby0  <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.hiwrite <= 1'b0;
      bus.lowrite <= 1'b0;
      bus.divby0  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_div   <= bus.op;
            a_mag    <= a_abs_in;
            b_mag    <= b_abs_in;
            res_neg  <= bus.a[31] ^ bus.b[31];
            rem_neg  <= bus.a[31];
            cnt      <= '0;
            rem      <= '0;
            acc      <= bus.op ? {32'd0, a_abs_in} : {32'd0, b_abs_in};
            bus.busy <= 1'b1;
            if (bus.op && (bus.b == '0)) begin
              // div-by-zero skips straight to DONE; hi/lo stay untouched
              state      <= DONE;
              bus.done   <= 1'b1;
              bus.divby0 <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 6'd1;
          if (op_div) begin
            rem <= div_ge ? div_diff : div_shift[31:0];
            acc <= {acc[63:32], acc[30:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[31:1]};
          end
          if (cnt == 6'd31) state <= SIGN;
        end
        SIGN: begin
          if (op_div) begin
            bus.hi <= r_signed;
            bus.lo <= q_signed;
          end else begin
            bus.hi <= prod_signed[63:32];
            bus.lo <= prod_signed[31:0];
          end
          bus.done    <= 1'b1;
          bus.hiwrite <= 1'b1;
          bus.lowrite <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
`timescale 1ns/1ps
module tb_muldiv_sequencer;

  logic clk;
  logic reset;
  int unsigned n_checks;
  int unsigned n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_sequencer_if bus();

  muldiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed 64-bit product, or C-style truncating division
  task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = m_hi;
    lo = m_lo;
    if (!op) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'($urandom_range(0, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_done(input int glitch_at, input bit hold, output int n);
    n = 0;
    while (!bus.done && n < 60) begin
      if (!hold) bus.start = (n == glitch_at);
      if (n == glitch_at) begin
        bus.op = 1'($urandom_range(0, 1));
        bus.a  = $urandom;
        bus.b  = $urandom;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!hold) bus.start = 1'b0;
    check("done_seen", bus.done, 1);
  endtask

  task automatic check_result(input logic [31:0] e_hi, input logic [31:0] e_lo,
                              input logic e_dz, input int n);
    check("latency", n, e_dz ? 0 : 33);
    check("busy_in_done", bus.busy, 1);
    check("hiwrite", bus.hiwrite, !e_dz);
    check("lowrite", bus.lowrite, !e_dz);
    check("divby0", bus.divby0, e_dz);
    check("hi", bus.hi, e_hi);
    check("lo", bus.lo, e_lo);
    m_hi = e_hi;
    m_lo = e_lo;
    @(posedge clk); #1;
    check("done_pulse", bus.done, 0);
    check("hiwrite_pulse", bus.hiwrite, 0);
    check("lowrite_pulse", bus.lowrite, 0);
    check("divby0_pulse", bus.divby0, 0);
    check("busy_idle", bus.busy, 0);
    check("hi_hold", bus.hi, m_hi);
    check("lo_hold", bus.lo, m_lo);
  endtask

  task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input int glitch_at);
    logic [31:0] e_hi, e_lo;
    logic        e_dz;
    int          n;
    model(op, a, b, e_hi, e_lo, e_dz);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 1'($urandom_range(0, 1));
    bus.a     = $urandom;
    bus.b     = $urandom;
    check("busy_after_start", bus.busy, 1);
    wait_done(glitch_at, 1'b0, n);
    check_result(e_hi, e_lo, e_dz, n);
  endtask

  initial begin
    logic [31:0] e_hi, e_lo;
    logic        e_dz;
    int          n;
    n_checks  = 0;
    n_fail    = 0;
    m_hi      = '0;
    m_lo      = '0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hiwrite", bus.hiwrite, 0);
    check("rst_lowrite", bus.lowrite, 0);
    check("rst_divby0", bus.divby0, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_op(1'b0, 32'hFFFF_FFFD, 32'd5, -1);
    check("mul_m3x5_hi", bus.hi, 32'hFFFF_FFFF);
    check("mul_m3x5_lo", bus.lo, 32'hFFFF_FFF1);

    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, -1);
    check("mul_min_hi", bus.hi, 32'h4000_0000);
    check("mul_min_lo", bus.lo, 32'h0000_0000);

    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1);
    check("div_m7_2_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_m7_2_hi", bus.hi, 32'hFFFF_FFFF);

    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, -1);
    check("div_7_m2_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_7_m2_hi", bus.hi, 32'd1);

    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'd0);

    // 0x891 / 0x40 = 0x22 rem 0x11, then divide by zero must leave them alone
    do_op(1'b1, 32'h891, 32'h40, -1);
    check("pre_div0_hi", bus.hi, 32'h11);
    check("pre_div0_lo", bus.lo, 32'h22);
    do_op(1'b1, 32'd100, 32'd0, -1);
    check("div0_hi", bus.hi, 32'h11);
    check("div0_lo", bus.lo, 32'h22);

    // start pulse mid-MULT is ignored
    do_op(1'b0, 32'd12345, 32'hFFFF_FF00, 10);

    // back-to-back with start held high
    model(1'b0, 32'd1000, 32'hFFFF_FFF0, e_hi, e_lo, e_dz);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd1000;
    bus.b     = 32'hFFFF_FFF0;
    @(posedge clk); #1;
    bus.op = 1'b1;
    bus.a  = 32'hFFFF_F000;
    bus.b  = 32'd7;
    check("b2b_busy", bus.busy, 1);
    wait_done(-1, 1'b1, n);
    check_result(e_hi, e_lo, e_dz, n);
    model(1'b1, 32'hFFFF_F000, 32'd7, e_hi, e_lo, e_dz);
    @(posedge clk); #1;
    check("b2b_accept", bus.busy, 1);
    bus.start = 1'b0;
    wait_done(-1, 1'b0, n);
    check_result(e_hi, e_lo, e_dz, n);

    // reset at cycle 20 of a DIV, with start asserted on the same edge
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'd99999;
    bus.b     = 32'd13;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd6;
    bus.b     = 32'd7;
    @(posedge clk); #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_hiwrite", bus.hiwrite, 0);
    check("mid_rst_lowrite", bus.lowrite, 0);
    check("mid_rst_divby0", bus.divby0, 0);
    check("mid_rst_hi", bus.hi, 0);
    check("mid_rst_lo", bus.lo, 0);
    m_hi      = '0;
    m_lo      = '0;
    reset     = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", bus.busy, 0);
    do_op(1'b0, 32'd6, 32'd7, -1);
    check("mul_6x7_lo", bus.lo, 32'd42);
    check("mul_6x7_hi", bus.hi, 32'd0);

    for (int i = 0; i < 40; i++) begin
      do_op(1'($urandom_range(0, 1)), pick(), pick(), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
